// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver (8 data bits, 1 stop, optional even parity via UART_RX_PARITY_EN).
// Latency: byte presented 1 clock after the stop-bit midpoint sample.
// Backpressure: single-entry output; a byte completing while the previous one is unaccepted is dropped (overrun pulse).
//
// Ports:
//   clock, reset      - system clock (rising edge), synchronous active-low reset
//   rx_in             - asynchronous serial line, idle high
//   data_out/_valid   - received byte and its valid flag, consumed when data_ready is high
//   data_ready        - downstream accepts data_out this cycle
//   frame_err         - one-clock pulse when the stop bit is sampled low
//   overrun           - one-clock pulse when a completed byte is dropped
//   parity_err        - one-clock pulse on parity mismatch (tied 0 unless UART_RX_PARITY_EN is defined)
module uart_rx_oversample #(
  parameter int CLKS_PER_BIT = 1252,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [SYNC_STAGES-1:0] sync_q;
  // fill_q tracks how many synchronizer stages hold real line samples since reset,
  // so the reset value of the sync flops is never mistaken for a high line.
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   armed_q;
  logic                   rxs;
  logic                   done;
  logic                   stop_bad;
  logic [7:0]             data_out_q;
  logic                   data_valid_q;
  logic                   frame_err_q;
  logic                   overrun_q;

  assign rxs = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q <= '1;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // After reset, start detection stays disabled until the real line is seen high
  // in IDLE, so the tail of an interrupted frame cannot look like a start bit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      armed_q <= 1'b0;
    end else if (state_q == S_IDLE && fill_q[SYNC_STAGES-1] && rxs) begin
      armed_q <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic par_bad;
  logic parity_err_q;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_bad = ^{shift_q, par_q};
`endif

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
`endif
    done     = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (armed_q && !rxs) begin
          state_d = S_START;
          tick_d  = '0;
        end
      end
      S_START: begin
        if (tick_q == TICK_HALF) begin
          tick_d  = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d         = '0;
          shift_d[idx_q] = rxs;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          par_d   = rxs;
          state_d = S_STOP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (rxs) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = S_WAIT_HIGH;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= stop_bad;
      overrun_q   <= done && data_valid_q && !data_ready;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= done && par_bad;
`endif
      // A completing byte may replace one being accepted in the same cycle.
      if (done && (!data_valid_q || data_ready)) begin
        data_out_q   <= shift_q;
        data_valid_q <= 1'b1;
      end else if (data_valid_q && data_ready) begin
        data_valid_q <= 1'b0;
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
`timescale 1ns/1ps
module tb_uart_rx_oversample;

  localparam int C    = 16;
  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  // Bits after the start midpoint up to and including the stop bit.
  localparam int NBITS = 8 + (PAR ? 1 : 0) + 1;
  // Line falling edge -> synchronizer -> IDLE sees low -> half bit -> NBITS bits -> +1 register.
  localparam int LAT = SYNC + 1 + C / 2 + NBITS * C + 1;

  logic       clock;
  logic       reset;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx_oversample #(.CLKS_PER_BIT(C), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .reset(reset), .rx_in(rx_in),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int exp_fe = 0, exp_ov = 0, exp_pe = 0, exp_pres = 0;
  int got_fe = 0, got_ov = 0, got_pe = 0, got_pres = 0;
  int vld_start = 0, run = 0, last_start = 0;
  logic [7:0] held = 8'h00;
  bit prev_v = 1'b0, prev_acc = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a new byte is presented.
  always @(negedge clock) begin
    if (reset !== 1'b1) begin
      prev_v   = 1'b0;
      prev_acc = 1'b0;
    end else begin
      if (frame_err === 1'b1)  got_fe++;
      if (overrun === 1'b1)    got_ov++;
      if (parity_err === 1'b1) got_pe++;
      if (data_valid === 1'b1) begin
        if (!prev_v || prev_acc) begin
          got_pres++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_byte: got 0x%0h expected none (t=%0t)", data_out, $time);
          end else begin
            chk("byte", int'(data_out), int'(exp_q.pop_front()));
          end
          vld_start = cyc;
          run       = 1;
          held      = data_out;
        end else begin
          run++;
          chk("hold", int'(data_out), int'(held));
        end
      end
      prev_v   = (data_valid === 1'b1);
      prev_acc = prev_v && (data_ready === 1'b1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic line_bit(input logic b);
    rx_in = b;
    tick(C);
  endtask

  // rst_bit >= 0 pulses reset for one clock in the middle of that data bit.
  task automatic send_frame(input logic [7:0] b, input logic pbit, input logic stopb, input int rst_bit);
    last_start = cyc;
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) begin
        rx_in = b[i];
        tick(C / 2);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(C - C / 2 - 1);
      end else begin
        line_bit(b[i]);
      end
    end
    if (PAR) line_bit(pbit);
    line_bit(stopb);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_frame_err"},  got_fe, exp_fe);
    chk({tag, "_overrun"},    got_ov, exp_ov);
    chk({tag, "_parity_err"}, got_pe, exp_pe);
    chk({tag, "_bytes"},      got_pres, exp_pres);
    chk({tag, "_pending"},    exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    logic       pbit;
    bit         good, pok;

    reset      = 1'b0;
    rx_in      = 1'b1;
    data_ready = 1'b1;
    tick(3);
    chk("rst_data_out",   int'(data_out), 0);
    chk("rst_data_valid", int'(data_valid), 0);
    chk("rst_frame_err",  int'(frame_err), 0);
    chk("rst_overrun",    int'(overrun), 0);
    chk("rst_parity_err", int'(parity_err), 0);
    reset = 1'b1;
    tick(10);

    // 0x55 with ready high: exact latency and single-cycle valid.
    exp_q.push_back(8'h55); exp_pres++;
    send_frame(8'h55, ^8'h55, 1'b1, -1);
    tick(2 * C);
    chk("latency_0x55", vld_start - last_start, LAT);
    chk("valid_width_0x55", run, 1);
    check_all("s55");

    // Short low glitch on the idle line.
    rx_in = 1'b0;
    tick(5);
    rx_in = 1'b1;
    tick(3 * C);
    check_all("glitch");

    // Bad stop bit followed by a long break, then a clean frame.
    send_frame(8'hA3, ^8'hA3, 1'b0, -1);
    exp_fe++;
    rx_in = 1'b0;
    tick(40);
    rx_in = 1'b1;
    tick(10);
    check_all("break");
    exp_q.push_back(8'h01); exp_pres++;
    send_frame(8'h01, ^8'h01, 1'b1, -1);
    tick(2 * C);
    check_all("after_break");

    // Overrun: downstream stalled across two frames.
    data_ready = 1'b0;
    exp_q.push_back(8'h11); exp_pres++;
    send_frame(8'h11, ^8'h11, 1'b1, -1);
    tick(4);
    send_frame(8'h22, ^8'h22, 1'b1, -1);
    exp_ov++;
    tick(2 * C);
    chk("ovr_data_out", int'(data_out), 8'h11);
    chk("ovr_valid", int'(data_valid), 1);
    check_all("overrun");
    data_ready = 1'b1;
    tick(2);
    chk("ovr_drained", int'(data_valid), 0);

    // Reset mid-DATA: the interrupted frame must not surface.
    send_frame(8'hF0, ^8'hF0, 1'b1, 2);
    tick(10);
    exp_q.push_back(8'h3C); exp_pres++;
    send_frame(8'h3C, ^8'h3C, 1'b1, -1);
    tick(2 * C);
    check_all("mid_reset");

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so parity bit 0 is a mismatch.
    exp_q.push_back(8'h07); exp_pres++;
    exp_pe++;
    send_frame(8'h07, 1'b0, 1'b1, -1);
    tick(2 * C);
    check_all("parity");
`endif

    // Randomized frames: random data, occasional bad stop / bad parity, random gaps.
    for (int n = 0; n < 16; n++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 5) != 0);
      pok  = ($urandom_range(0, 3) != 0);
      pbit = pok ? ^b : ~^b;
      if (good) begin
        exp_q.push_back(b);
        exp_pres++;
        if (PAR && !pok) exp_pe++;
      end else begin
        exp_fe++;
      end
      send_frame(b, pbit, good, -1);
      if (!good) begin
        rx_in = 1'b0;
        tick(int'($urandom_range(0, 20)));
      end
      rx_in = 1'b1;
      tick(int'($urandom_range(4, 30)));
    end
    tick(2 * C);
    check_all("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 1252, meaning system clocks per UART bit; legal range 4..65535.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, meaning the number of rx_in synchronizer flops; legal range 2..3.
REQ-003 SHALL have port clock, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port rx_in, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port data_out, output, 8, received byte, LSB first on the line.
REQ-007 SHALL have port data_valid, output, 1, data_out holds an unconsumed byte.
REQ-008 SHALL have port data_ready, input, 1, downstream FIFO accepts data_out this cycle.
REQ-009 SHALL have port frame_err, output, 1, one-clock pulse when the stop bit is sampled low.
REQ-010 SHALL have port overrun, output, 1, one-clock pulse when a completed byte is dropped.
REQ-011 SHALL have port parity_err, output, 1, one-clock pulse on parity mismatch (see Configuration).

Function
REQ-012 SHALL pass rx_in through SYNC_STAGES flops; all decisions use the synchronized value rxs.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-014 IDLE: SHALL move to START on rxs==0 and clear the tick counter.
REQ-015 START: SHALL sample at tick CLKS_PER_BIT/2 (integer division); rxs==1 -> IDLE (false start, no flags); rxs==0 -> DATA with tick counter restarted.
REQ-016 DATA: SHALL sample every CLKS_PER_BIT ticks from the start midpoint and shift into bit[0..7]; a 3-bit index wraps 7->0 on leaving for PARITY/STOP.
REQ-017 STOP: SHALL sample at the stop midpoint; rxs==1 -> byte complete, IDLE; rxs==0 -> frame_err pulse, byte discarded, WAIT_HIGH.
REQ-018 WAIT_HIGH: SHALL stay until rxs==1, then IDLE; no start detection meanwhile (break handling).
REQ-019 SHALL load data_out and set data_valid on the clock after the stop-midpoint sample (latency 1).
REQ-020 SHALL clear data_valid on a clock with data_valid==1 and data_ready==1, unless a byte completes in the same cycle.
REQ-021 SHALL, on simultaneous completion and acceptance, load the new byte and keep data_valid=1.
REQ-022 SHALL, on completion while data_valid==1 and data_ready==0, keep the old data_out, drop the new byte, and pulse overrun.
REQ-023 SHALL hold data_out stable while data_valid==1 and not accepted.
REQ-024 SHALL use a tick counter of ceil(log2(CLKS_PER_BIT)) bits that never exceeds CLKS_PER_BIT-1.
REQ-025 SHALL not change the FSM state on data_ready.

Reset
REQ-026 SHALL, on reset==0 at a clock edge, force IDLE, tick=0, index=0, data_out=8'h00, data_valid=0, frame_err=0, overrun=0, parity_err=0, and synchronizer flops=1.
REQ-027 SHALL abort any reception on reset mid-frame; after release, the remaining frame bits SHALL be discarded until rxs is seen high in IDLE and a new falling edge occurs.

Configuration
REQ-028 With macro UART_RX_PARITY_EN defined, SHALL insert state PARITY after DATA, sample the bit at its midpoint, and check even parity over data+parity bit.
REQ-029 With UART_RX_PARITY_EN defined, a mismatch SHALL pulse parity_err at the completion cycle and still deliver the byte; a mismatch with frame error SHALL give frame_err only.
REQ-030 Without UART_RX_PARITY_EN, DATA SHALL go directly to STOP and parity_err SHALL be tied 0.

Verification (bench CLKS_PER_BIT=16)
REQ-031 Send 0x55 with 8N1 and data_ready=1: data_out=0x55, data_valid high 1 clock, starting 1 clock after the stop midpoint.
REQ-032 Drive a 5-clock low glitch on the idle line: no data_valid, no flags, FSM back in IDLE.
REQ-033 Send 0xA3 with the stop bit low, then 40 low clocks, then high: frame_err single pulse; no data_valid; next 0x01 received correctly.
REQ-034 Hold data_ready=0 and send 0x11 then 0x22: data_out stays 0x11, overrun pulses once at the 0x22 completion.
REQ-035 Assert reset for 1 clock mid-DATA of 0xF0, then send 0x3C: only 0x3C is delivered.
REQ-036 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0: data_out=0x07, data_valid=1, parity_err pulses once.
